bus_dma_master: RTL and testbench

- Bus initiator on the master port of the shared bus.
- Copies a block of 64-bit words from a source region to a destination region, both reachable through the bus address decoder.
- Requests the bus, waits for grant, then performs alternating single-word read and write cycles.
- Releases the bus and pulses done when the copy is complete.
- Sits between a control source (CPU, test harness) and the bus master port.

---
 rtl/bus_dma_master_pkg.sv | 18 +
 rtl/bus_dma_master_if.sv | 27 ++
 rtl/bus_dma_master.sv | 131 +++++++++++++
 tb/tb_bus_dma_master.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_dma_master_pkg.sv
// Shared definitions for the bus DMA master and the bus it drives.
// Holds the bus width constants that the bus interface and slaves reuse, and
// the 3-bit FSM state encoding of the copy engine.
package bus_dma_master_pkg;

  localparam int unsigned ADDR_W = 16;  // bus word-address width
  localparam int unsigned DATA_W = 64;  // bus data width

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD   = 3'd2,
    ST_RDW  = 3'd3,
    ST_WR   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/bus_dma_master_if.sv
// Shared-bus master port.
//   m_req   : request to arbiter          (master -> arbiter)
//   m_wr    : 1 = write cycle, 0 = read   (master -> slave)
//   m_addr  : word address                (master -> slave)
//   m_dout  : write data                  (master -> slave)
//   m_grant : grant from arbiter          (arbiter -> master)
//   m_din   : read data, valid the cycle after the read address
interface bus_dma_master_if;
  import bus_dma_master_pkg::*;

  logic              m_req;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_dout;
  logic              m_grant;
  logic [DATA_W-1:0] m_din;

  modport master (
    output m_req, m_wr, m_addr, m_dout,
    input  m_grant, m_din
  );

  modport slave (
    input  m_req, m_wr, m_addr, m_dout,
    output m_grant, m_din
  );
endinterface

// File: rtl/bus_dma_master.sv
// Bus DMA master: copies i_len 64-bit words from i_src_addr to i_dst_addr over
// the shared bus using alternating single-word read / write cycles.
//   clk, reset      : clock, asynchronous active-high reset
//   i_start         : one-cycle start pulse, accepted only in IDLE
//   i_src_addr      : first source word address
//   i_dst_addr      : first destination word address
//   i_len           : number of words (0 completes without touching the bus)
//   o_busy          : high from the cycle after an accepted start until IDLE
//   o_done          : one-cycle completion pulse
//   m_bus (master)  : shared-bus master port
// Address/data widths come from the shared package so bus and slaves agree.
module bus_dma_master
  import bus_dma_master_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [ADDR_W-1:0]  i_src_addr,
  input  logic [ADDR_W-1:0]  i_dst_addr,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_busy,
  output logic               o_done,
  bus_dma_master_if.master   m_bus
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_rem;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr;
  logic              r_req;
  logic              r_wr;
  logic              r_busy;
  logic              r_done;

  // Every output register is loaded with the value belonging to the state
  // being entered, so outputs are pure register values with no path from
  // m_grant or m_din.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_data  <= '0;
      r_addr  <= '0;
      r_req   <= 1'b0;
      r_wr    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_busy <= 1'b1;
            if (i_len != '0) begin
              r_src   <= i_src_addr;
              r_dst   <= i_dst_addr;
              r_rem   <= i_len;
              r_req   <= 1'b1;
              r_state <= ST_REQ;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_REQ: begin
          if (m_bus.m_grant) begin
            r_addr  <= r_src;
            r_state <= ST_RD;
          end
        end
        ST_RD: begin
          r_state <= m_bus.m_grant ? ST_RDW : ST_REQ;
        end
        ST_RDW: begin
          if (m_bus.m_grant) begin
            r_data  <= m_bus.m_din;
            r_wr    <= 1'b1;
            r_addr  <= r_dst;
            r_state <= ST_WR;
          end else begin
            r_state <= ST_REQ;
          end
        end
        ST_WR: begin
          r_wr <= 1'b0;
          if (!m_bus.m_grant) begin
            // Word abandoned: pointers untouched, the same word is re-read.
            r_state <= ST_REQ;
          end else begin
            r_src <= r_src + ADDR_W'(1);
            r_dst <= r_dst + ADDR_W'(1);
            r_rem <= r_rem - LEN_W'(1);
            if (r_rem == LEN_W'(1)) begin
              r_req   <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_addr  <= r_src + ADDR_W'(1);
              r_state <= ST_RD;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_wr    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign m_bus.m_req  = r_req;
  assign m_bus.m_wr   = r_wr;
  assign m_bus.m_addr = r_addr;
  assign m_bus.m_dout = r_data;

endmodule

// File: tb/tb_bus_dma_master.sv
module tb_bus_dma_master;
  import bus_dma_master_pkg::*;

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [7:0]  len;
    bit          restart;
    int unsigned exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_src_addr = '0;
  logic [15:0] i_dst_addr = '0;
  logic [7:0]  i_len = '0;
  logic        o_busy;
  logic        o_done;

  bus_dma_master_if bus ();

  bus_dma_master #(.LEN_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (i_start),
    .i_src_addr (i_src_addr),
    .i_dst_addr (i_dst_addr),
    .i_len      (i_len),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .m_bus      (bus)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned wr_count = 0;
  bit          req_s = 1'b0;
  bit          req_seen = 1'b0;
  bit          drop = 1'b0;
  logic [63:0] mem [logic [15:0]];
  wr_t         sbq [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Arbiter model: grant follows the request one cycle later unless dropped.
  always @(posedge clk) bus.m_grant <= req_s && !drop;

  // Slave model and write scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      req_s = 1'b0;
    end else begin
      req_s = bus.m_req;
      if (bus.m_req) req_seen = 1'b1;
      if (bus.m_req && !bus.m_wr)
        bus.m_din = mem.exists(bus.m_addr) ? mem[bus.m_addr] : 64'h0;
      if (bus.m_req && bus.m_wr && bus.m_grant) begin
        wr_t e;
        wr_count++;
        mem[bus.m_addr] = bus.m_dout;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra_write actual addr=%h data=%h expected no write",
                   bus.m_addr, bus.m_dout);
        end else begin
          e = sbq.pop_front();
          chk("sb_wr_addr", 64'(bus.m_addr), 64'(e.addr));
          chk("sb_wr_data", bus.m_dout, e.data);
        end
      end
    end
  end

  task automatic run_copy(input logic [15:0] src, input logic [15:0] dst,
                          input logic [7:0] len, input bit restart,
                          input bit do_drop, input int unsigned exp_lat);
    int unsigned cyc;
    int unsigned wr0;
    bit          got_done;
    for (int unsigned i = 0; i < 32'(len); i++) begin
      logic [15:0] sa;
      logic [15:0] da;
      logic [63:0] d;
      sa = src + 16'(i);
      da = dst + 16'(i);
      d  = {$urandom(), src, 16'(i)};
      mem[sa] = d;
      sbq.push_back('{da, d});
    end
    req_seen = 1'b0;
    wr0 = wr_count;
    @(negedge clk);
    i_src_addr = src;
    i_dst_addr = dst;
    i_len      = len;
    i_start    = 1'b1;
    cyc = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 3 + 3 * 32'(len) + 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        i_start = 1'b0;
        chk("busy_after_start", 64'(o_busy), 64'd1);
      end
      if (o_done) begin
        got_done = 1'b1;
      end else begin
        if (restart && cyc == 2) begin
          i_start = 1'b1;
          i_src_addr = 16'hAAAA;
          i_dst_addr = 16'h5555;
          i_len = 8'd7;
        end
        if (restart && cyc == 3) i_start = 1'b0;
        if (do_drop && cyc == 6) drop = 1'b1;
        if (do_drop && cyc == 8) drop = 1'b0;
      end
    end
    chk("done_seen", 64'(got_done), 64'd1);
    chk("latency", 64'(cyc), 64'(exp_lat));
    @(negedge clk);
    chk("done_one_cycle", 64'(o_done), 64'd0);
    chk("busy_falls", 64'(o_busy), 64'd0);
    chk("write_count", 64'(wr_count - wr0), 64'(len));
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    if (len == 8'd0) chk("len0_no_req", 64'(req_seen), 64'd0);
    sbq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs [5];
    int unsigned wr_snap;
    vecs[0] = '{16'h0010, 16'h7000, 8'd1, 1'b0, 6};
    vecs[1] = '{16'h0100, 16'h7100, 8'd4, 1'b0, 15};
    vecs[2] = '{16'h0200, 16'h7200, 8'd0, 1'b0, 1};
    vecs[3] = '{16'hFFFF, 16'h7300, 8'd2, 1'b0, 9};
    vecs[4] = '{16'h1234, 16'h7400, 8'd5, 1'b1, 18};

    bus.m_grant = 1'b0;
    bus.m_din = '0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_req", 64'(bus.m_req), 64'd0);
    chk("rst_wr", 64'(bus.m_wr), 64'd0);
    chk("rst_addr", 64'(bus.m_addr), 64'd0);
    chk("rst_dout", bus.m_dout, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single word, cycle-accurate
    mem[16'h0010] = 64'hDEADBEEF_01234567;
    sbq.push_back('{16'h7000, 64'hDEADBEEF_01234567});
    i_src_addr = 16'h0010; i_dst_addr = 16'h7000; i_len = 8'd1; i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;                         // cycle 1
    chk("c1_req", 64'(bus.m_req), 64'd1);
    chk("c1_wr", 64'(bus.m_wr), 64'd0);
    @(negedge clk);                                         // cycle 2
    chk("c2_done", 64'(o_done), 64'd0);
    @(negedge clk);                                         // cycle 3
    chk("c3_req", 64'(bus.m_req), 64'd1);
    chk("c3_wr", 64'(bus.m_wr), 64'd0);
    chk("c3_addr", 64'(bus.m_addr), 64'h0010);
    @(negedge clk);                                         // cycle 4
    chk("c4_wr", 64'(bus.m_wr), 64'd0);
    chk("c4_addr", 64'(bus.m_addr), 64'h0010);
    @(negedge clk);                                         // cycle 5
    chk("c5_wr", 64'(bus.m_wr), 64'd1);
    chk("c5_addr", 64'(bus.m_addr), 64'h7000);
    chk("c5_dout", bus.m_dout, 64'hDEADBEEF_01234567);
    @(negedge clk);                                         // cycle 6
    chk("c6_done", 64'(o_done), 64'd1);
    chk("c6_req", 64'(bus.m_req), 64'd0);
    @(negedge clk);                                         // cycle 7
    chk("c7_done", 64'(o_done), 64'd0);
    chk("c7_busy", 64'(o_busy), 64'd0);
    chk("single_mem", mem[16'h7000], 64'hDEADBEEF_01234567);
    chk("single_sb", 64'(sbq.size()), 64'd0);
    sbq.delete();

    // Table-driven copies
    for (int unsigned v = 0; v < 5; v++)
      run_copy(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].restart, 1'b0, vecs[v].exp_lat);

    // Grant dropped for two cycles during RDW of the second word
    run_copy(16'h0400, 16'h7600, 8'd3, 1'b0, 1'b1, 16);

    // Reset during WR of the second word
    for (int unsigned i = 0; i < 4; i++) mem[16'h0300 + 16'(i)] = 64'h5A5A_0000_0000_0000 + 64'(i);
    sbq.push_back('{16'h7500, 64'h5A5A_0000_0000_0000});
    @(negedge clk);
    i_src_addr = 16'h0300; i_dst_addr = 16'h7500; i_len = 8'd4; i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    repeat (6) @(negedge clk);                              // now cycle 7
    @(posedge clk); #1;                                     // cycle 8
    chk("pre_rst_wr", 64'(bus.m_wr), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_done", 64'(o_done), 64'd0);
    chk("mid_rst_req", 64'(bus.m_req), 64'd0);
    chk("mid_rst_wr", 64'(bus.m_wr), 64'd0);
    chk("mid_rst_addr", 64'(bus.m_addr), 64'd0);
    chk("mid_rst_dout", bus.m_dout, 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_word0_only", 64'(sbq.size()), 64'd0);
    sbq.delete();
    wr_snap = wr_count;
    repeat (6) @(negedge clk);
    chk("post_rst_no_wr", 64'(wr_count - wr_snap), 64'd0);
    chk("post_rst_busy", 64'(o_busy), 64'd0);
    chk("post_rst_req", 64'(bus.m_req), 64'd0);
    run_copy(16'h0500, 16'h7700, 8'd2, 1'b0, 1'b0, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
